// File: rtl/communication_unit.sv
// communication_unit: handles the start/stop/end commands from the fetch unit, stalls fetch, and publishes stop masks
module communication_unit #(
    parameter int STOP_DRAIN_CYCLES = 4,
    parameter int SIGNAL_WIDTH      = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    communication_enable_in,
    input  logic [SIGNAL_WIDTH+2:0] communication_signal_in,
    input  logic [SIGNAL_WIDTH-1:0] process_done_in,
    output logic                    wait_for_next_out,
    output logic [SIGNAL_WIDTH-1:0] signals_out,
    output logic                    signal_valid_out,
    output logic                    finished_out,
    output logic                    error_out
);
    localparam int CW = $clog2(STOP_DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DEP_WAIT, RUN, STOP_DRAIN, FINISHED} state_t;

    state_t                  r_state, w_state;
    logic [SIGNAL_WIDTH-1:0] r_mask, w_mask, r_signals, w_signals;
    logic [CW-1:0]           r_cnt, w_cnt;
    logic                    r_wait, w_wait, r_valid, w_valid;
    logic                    r_finished, w_finished, r_error, w_error;

    logic [1:0]              w_op;
    logic                    w_dep;
    logic [SIGNAL_WIDTH-1:0] w_cmd_mask;

    assign w_op       = communication_signal_in[SIGNAL_WIDTH+2:SIGNAL_WIDTH+1];
    assign w_dep      = communication_signal_in[SIGNAL_WIDTH];
    assign w_cmd_mask = communication_signal_in[SIGNAL_WIDTH-1:0];

    assign wait_for_next_out = r_wait;
    assign signals_out       = r_signals;
    assign signal_valid_out  = r_valid;
    assign finished_out      = r_finished;
    assign error_out         = r_error;

    // Next state and next registered outputs; commands only matter in IDLE and RUN
    always_comb begin
        w_state    = r_state;
        w_mask     = r_mask;
        w_cnt      = r_cnt;
        w_wait     = r_wait;
        w_signals  = r_signals;
        w_valid    = 1'b0;
        w_finished = r_finished;
        w_error    = r_error;
        case (r_state)
            IDLE: begin
                if (communication_enable_in) begin
                    if (w_op == 2'b10) begin
                        if (w_dep && w_cmd_mask != '0) begin
                            w_state = DEP_WAIT;
                            w_mask  = w_cmd_mask;
                            w_wait  = 1'b1;
                        end else begin
                            w_state = RUN;
                        end
                    end else if (w_op == 2'b00) begin
                        w_state    = FINISHED;
                        w_wait     = 1'b1;
                        w_finished = 1'b1;
                    end else begin
                        w_error = 1'b1;
                    end
                end
            end
            DEP_WAIT: begin
                if ((process_done_in & r_mask) == r_mask) begin
                    w_state = RUN;
                    w_wait  = 1'b0;
                end
            end
            RUN: begin
                if (communication_enable_in) begin
                    if (w_op == 2'b11) begin
                        w_state = STOP_DRAIN;
                        w_mask  = w_cmd_mask;
                        w_wait  = 1'b1;
                        w_cnt   = CW'(STOP_DRAIN_CYCLES - 1);
                    end else if (w_op == 2'b00) begin
                        w_state    = FINISHED;
                        w_wait     = 1'b1;
                        w_finished = 1'b1;
                    end else begin
                        w_error = 1'b1;
                    end
                end
            end
            STOP_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state   = IDLE;
                    w_signals = r_mask;
                    w_valid   = 1'b1;
                    w_wait    = 1'b0;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            FINISHED: begin
                w_wait     = 1'b1;
                w_finished = 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_wait     <= 1'b0;
            r_signals  <= '0;
            r_valid    <= 1'b0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_mask     <= w_mask;
            r_cnt      <= w_cnt;
            r_wait     <= w_wait;
            r_signals  <= w_signals;
            r_valid    <= w_valid;
            r_finished <= w_finished;
            r_error    <= w_error;
        end
    end
endmodule

// File: tb/tb_communication_unit.sv
// tb_communication_unit: directed plus random stimulus checked against a cycle-level behavioural model
module tb_communication_unit;
    localparam int SW = 16;
    localparam int SD = 4;
    localparam int M_IDLE = 0, M_DEP = 1, M_RUN = 2, M_DRAIN = 3, M_FIN = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [SW+2:0] sig = '0;
    logic [SW-1:0] pd = '0;
    logic          wait_o, valid_o, fin_o, err_o;
    logic [SW-1:0] sigs_o;

    int n_tests = 0, n_fail = 0, n_wait = 0, n_valid = 0;

    int          m_mode = M_IDLE, m_left = 0;
    logic [SW-1:0] m_mask = '0, m_sigs = '0;
    logic        m_wait = 0, m_valid = 0, m_fin = 0, m_err = 0;

    communication_unit #(.STOP_DRAIN_CYCLES(SD), .SIGNAL_WIDTH(SW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .communication_enable_in(en),
        .communication_signal_in(sig),
        .process_done_in(pd),
        .wait_for_next_out(wait_o),
        .signals_out(sigs_o),
        .signal_valid_out(valid_o),
        .finished_out(fin_o),
        .error_out(err_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SW+2:0] cmd(input logic [1:0] op, input logic dep, input logic [SW-1:0] mask);
        return {op, dep, mask};
    endfunction

    // Reference: what the unit should do at one clock edge given the inputs present at it
    task automatic model_edge();
        logic [1:0] op;
        op = sig[SW+2:SW+1];
        m_valid = 0;
        if (!reset_n) begin
            m_mode = M_IDLE; m_left = 0; m_mask = '0; m_sigs = '0;
            m_wait = 0; m_fin = 0; m_err = 0;
        end else if (m_mode == M_IDLE || m_mode == M_RUN) begin
            if (en) begin
                if (op == 2'b00) begin
                    m_mode = M_FIN; m_wait = 1; m_fin = 1;
                end else if (m_mode == M_IDLE && op == 2'b10) begin
                    if (sig[SW] && sig[SW-1:0] != 0) begin
                        m_mode = M_DEP; m_mask = sig[SW-1:0]; m_wait = 1;
                    end else m_mode = M_RUN;
                end else if (m_mode == M_RUN && op == 2'b11) begin
                    m_mode = M_DRAIN; m_mask = sig[SW-1:0]; m_wait = 1; m_left = SD;
                end else m_err = 1;
            end
        end else if (m_mode == M_DEP) begin
            if ((pd & m_mask) == m_mask) begin
                m_mode = M_RUN; m_wait = 0;
            end
        end else if (m_mode == M_DRAIN) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = M_IDLE; m_sigs = m_mask; m_valid = 1; m_wait = 0;
            end
        end
    endtask

    task automatic step(input logic e, input logic [SW+2:0] s, input logic [SW-1:0] p, input logic rn);
        en = e; sig = s; pd = p; reset_n = rn;
        @(posedge clock);
        model_edge();
        #1;
        check("outputs", {12'd0, wait_o, sigs_o, valid_o, fin_o, err_o},
                         {12'd0, m_wait, m_sigs, m_valid, m_fin, m_err});
        if (wait_o) n_wait++;
        if (valid_o) n_valid++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 1);
    endtask

    initial begin
        step(0, '0, '0, 0);
        step(0, '0, '0, 0);
        check("reset_wait", {31'd0, wait_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);

        step(1, cmd(2'b10, 0, 16'h0000), '0, 1);
        check("indep_start_wait", {31'd0, wait_o}, 32'd0);
        idle(2);

        n_wait = 0; n_valid = 0;
        step(1, cmd(2'b11, 0, 16'hA5A5), '0, 1);
        idle(6);
        check("drain_wait_cycles", n_wait, SD);
        check("drain_valid_pulses", n_valid, 1);
        check("drain_signals", {16'd0, sigs_o}, 32'h0000A5A5);

        step(1, cmd(2'b10, 1, 16'h21E6), '0, 1);
        check("dep_wait_high", {31'd0, wait_o}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, '0, '0, 1);
        step(1, cmd(2'b11, 0, 16'hFFFF), 16'h21E6, 1);
        check("dep_release", {31'd0, wait_o}, 32'd0);
        check("dep_no_err", {31'd0, err_o}, 32'd0);

        step(1, cmd(2'b01, 0, 16'h0000), '0, 1);
        check("reserved_in_run", {31'd0, err_o}, 32'd1);
        step(1, cmd(2'b11, 0, 16'h1234), '0, 1);
        check("run_kept_after_err", {31'd0, wait_o}, 32'd1);
        idle(5);

        step(0, '0, '0, 0);
        step(1, cmd(2'b10, 1, 16'h21E6), '0, 1);
        for (int i = 0; i < 8; i++) step(0, '0, 16'h21E4, 1);
        check("dep_partial_stall", {31'd0, wait_o}, 32'd1);
        step(0, '0, 16'h21E6, 0);
        check("reset_mid_dep", {31'd0, wait_o}, 32'd0);

        step(1, cmd(2'b10, 0, 16'h0), '0, 1);
        n_valid = 0;
        step(1, cmd(2'b11, 0, 16'hBEEF), '0, 1);
        step(0, '0, '0, 1);
        step(0, '0, '0, 0);
        idle(6);
        check("reset_mid_drain_no_pulse", n_valid, 0);

        step(1, cmd(2'b11, 0, 16'h0F0F), '0, 1);
        check("stop_in_idle_err", {31'd0, err_o}, 32'd1);
        idle(2);
        check("err_sticky", {31'd0, err_o}, 32'd1);

        step(0, '0, '0, 0);
        step(1, cmd(2'b10, 0, 16'h0), '0, 1);
        step(1, cmd(2'b00, 0, 16'h0), '0, 1);
        check("end_finished", {30'd0, fin_o, wait_o}, 32'd3);
        step(1, cmd(2'b10, 1, 16'h00FF), '0, 1);
        step(1, cmd(2'b01, 0, 16'h0), '0, 1);
        check("finished_ignores", {29'd0, fin_o, wait_o, err_o}, 32'd6);

        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [1:0] op;
            logic [SW-1:0] mk;
            r = $urandom_range(0, 9);
            op = (r < 4 || r == 9) ? 2'b10 : (r < 7) ? 2'b11 : (r == 7) ? 2'b00 : 2'b01;
            mk = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
            step($urandom_range(0, 2) == 0, cmd(op, 1'($urandom), mk),
                 ($urandom_range(0, 3) == 0) ? '1 : SW'($urandom),
                 $urandom_range(0, 40) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
